// File: rtl/mem_bus_arbiter.sv
// Two-requester (instruction fetch / load-store) arbiter onto one memory port; one outstanding bus transaction.
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort stalled transactions after TIMEOUT_CYCLES cycles.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic [31:0] ABORT_RDATA = 32'hDEADBEEF;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;          // 1 = data requester owns the bus
  logic        last_data_q, last_data_d;  // 1 = last completed grant was data
  logic [31:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        bus_req_q, bus_req_d;
  logic        busy_q, busy_d;
  logic        inst_ok_q, inst_ok_d;
  logic        data_ok_q, data_ok_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;
  logic        timeout_err_q, timeout_err_d;

  logic        inst_pend_s;
  logic        data_pend_s;
  logic        grant_data_s;
  logic        abort_s;

  // A requester still holds req during its own ok cycle; that req is the one just served, so mask it.
  assign inst_pend_s  = inst_req & ~inst_ok_q;
  assign data_pend_s  = data_req & ~data_ok_q;
  assign grant_data_s = data_pend_s & (~inst_pend_s | ~last_data_q);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_CYCLES);

  logic [31:0] cnt_q, cnt_d;
  logic [31:0] cnt_inc_s;

  assign cnt_inc_s = cnt_q + 32'd1;

  // Stall counter: restarts on grant and on address acceptance, counts cycles without progress.
  always_comb begin
    cnt_d   = cnt_q;
    abort_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 32'd0;
      end
      ST_ADDR: begin
        if (bus_addr_ok) begin
          cnt_d = 32'd0;
        end else begin
          cnt_d   = cnt_inc_s;
          abort_s = (cnt_inc_s >= TO_LIMIT);
        end
      end
      ST_WAIT: begin
        if (bus_data_ok) begin
          cnt_d = 32'd0;
        end else begin
          cnt_d   = cnt_inc_s;
          abort_s = (cnt_inc_s >= TO_LIMIT);
        end
      end
      default: begin
        cnt_d = 32'd0;
      end
    endcase
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_cfg_s;

  assign abort_s      = 1'b0;
  assign unused_cfg_s = ^(32'(TIMEOUT_CYCLES));
`endif

  // Next-state, grant latching and completion pulses.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_data_d   = last_data_q;
    addr_d        = addr_q;
    wr_d          = wr_q;
    be_d          = be_q;
    wdata_d       = wdata_q;
    bus_req_d     = bus_req_q;
    busy_d        = busy_q;
    inst_ok_d     = 1'b0;
    data_ok_d     = 1'b0;
    inst_rdata_d  = inst_rdata_q;
    data_rdata_d  = data_rdata_q;
    timeout_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (inst_pend_s | data_pend_s) begin
          owner_d = grant_data_s;
          if (grant_data_s) begin
            addr_d  = data_addr;
            wr_d    = data_wr;
            be_d    = data_be;
            wdata_d = data_wdata;
          end else begin
            addr_d  = inst_addr;
            wr_d    = 1'b0;
            be_d    = 4'b1111;
            wdata_d = 32'd0;
          end
          // A store with no enabled lanes never reaches the bus; acknowledge it directly.
          if (grant_data_s && data_wr && (data_be == 4'b0000)) begin
            data_ok_d   = 1'b1;
            last_data_d = 1'b1;
            state_d     = ST_IDLE;
            bus_req_d   = 1'b0;
            busy_d      = 1'b0;
          end else begin
            state_d   = ST_ADDR;
            bus_req_d = 1'b1;
            busy_d    = 1'b1;
          end
        end else begin
          state_d   = ST_IDLE;
          bus_req_d = 1'b0;
          busy_d    = 1'b0;
        end
      end

      ST_ADDR: begin
        if (bus_addr_ok && bus_data_ok) begin
          state_d     = ST_IDLE;
          bus_req_d   = 1'b0;
          busy_d      = 1'b0;
          last_data_d = owner_q;
          if (owner_q) begin
            data_ok_d    = 1'b1;
            data_rdata_d = bus_rdata;
          end else begin
            inst_ok_d    = 1'b1;
            inst_rdata_d = bus_rdata;
          end
        end else if (bus_addr_ok) begin
          state_d   = ST_WAIT;
          bus_req_d = 1'b0;
        end else if (abort_s) begin
          state_d       = ST_IDLE;
          bus_req_d     = 1'b0;
          busy_d        = 1'b0;
          last_data_d   = owner_q;
          timeout_err_d = 1'b1;
          if (owner_q) begin
            data_ok_d    = 1'b1;
            data_rdata_d = ABORT_RDATA;
          end else begin
            inst_ok_d    = 1'b1;
            inst_rdata_d = ABORT_RDATA;
          end
        end else begin
          state_d = ST_ADDR;
        end
      end

      ST_WAIT: begin
        if (bus_data_ok) begin
          state_d     = ST_IDLE;
          busy_d      = 1'b0;
          last_data_d = owner_q;
          if (owner_q) begin
            data_ok_d    = 1'b1;
            data_rdata_d = bus_rdata;
          end else begin
            inst_ok_d    = 1'b1;
            inst_rdata_d = bus_rdata;
          end
        end else if (abort_s) begin
          state_d       = ST_IDLE;
          busy_d        = 1'b0;
          last_data_d   = owner_q;
          timeout_err_d = 1'b1;
          if (owner_q) begin
            data_ok_d    = 1'b1;
            data_rdata_d = ABORT_RDATA;
          end else begin
            inst_ok_d    = 1'b1;
            inst_rdata_d = ABORT_RDATA;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        bus_req_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  // State, latched request fields and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      owner_q       <= 1'b0;
      last_data_q   <= 1'b0;
      addr_q        <= 32'd0;
      wr_q          <= 1'b0;
      be_q          <= 4'b0000;
      wdata_q       <= 32'd0;
      bus_req_q     <= 1'b0;
      busy_q        <= 1'b0;
      inst_ok_q     <= 1'b0;
      data_ok_q     <= 1'b0;
      inst_rdata_q  <= 32'd0;
      data_rdata_q  <= 32'd0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_data_q   <= last_data_d;
      addr_q        <= addr_d;
      wr_q          <= wr_d;
      be_q          <= be_d;
      wdata_q       <= wdata_d;
      bus_req_q     <= bus_req_d;
      busy_q        <= busy_d;
      inst_ok_q     <= inst_ok_d;
      data_ok_q     <= data_ok_d;
      inst_rdata_q  <= inst_rdata_d;
      data_rdata_q  <= data_rdata_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign inst_ok     = inst_ok_q;
  assign inst_rdata  = inst_rdata_q;
  assign data_ok     = data_ok_q;
  assign data_rdata  = data_rdata_q;
  assign bus_req     = bus_req_q;
  assign bus_wr      = wr_q;
  assign bus_be      = be_q;
  assign bus_addr    = addr_q;
  assign bus_wdata   = wdata_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: expected completions queued when bus responses are driven.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_ok;
  logic [31:0] data_rdata;
  logic        bus_req;
  logic        bus_wr;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;
  logic        busy;
  logic        timeout_err;

  typedef struct {
    bit          is_data;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   inst_ok_cnt = 0;
  int   data_ok_cnt = 0;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_ok(inst_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_be(data_be), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_ok(data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_be(bus_be), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (inst_ok === 1'b1) inst_ok_cnt++;
    if (data_ok === 1'b1) data_ok_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for bus_req, then answers after the given delays; returns at the ok cycle.
  task automatic bus_serve(input int addr_wait, input int data_wait, input logic [31:0] rd, output bit done);
    int guard;
    done  = 1'b0;
    guard = 0;
    while (bus_req !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    if (bus_req === 1'b1) begin
      for (int i = 0; i < addr_wait; i++) tick();
      bus_addr_ok = 1'b1;
      if (data_wait == 0) begin
        bus_data_ok = 1'b1;
        bus_rdata   = rd;
      end
      tick();
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
      if (data_wait > 0) begin
        for (int i = 1; i < data_wait; i++) tick();
        bus_data_ok = 1'b1;
        bus_rdata   = rd;
        tick();
        bus_data_ok = 1'b0;
      end
      done = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [140:0] all_out;
    rst = 1'b1;
    tick();
    tick();
    all_out = {inst_ok, inst_rdata, data_ok, data_rdata, bus_req, bus_wr, bus_be,
               bus_addr, bus_wdata, busy, timeout_err};
    n_checks++;
    if (all_out !== 141'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, expected 0", all_out);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0 || bus_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b bus_req=%b, expected 0 0", busy, bus_req);
    end
  endtask

  task automatic test_inst_fetch();
    exp_t e;
    inst_req  = 1'b1;
    inst_addr = 32'hBFC00000;
    tick();
    n_checks++;
    if ({bus_req, bus_wr, bus_be, bus_addr} !== {1'b1, 1'b0, 4'b1111, 32'hBFC00000}) begin
      n_fail++;
      $display("FAIL fetch_bus_fields: got req=%b wr=%b be=%b addr=%h, expected 1 0 1111 bfc00000",
               bus_req, bus_wr, bus_be, bus_addr);
    end
    bus_addr_ok = 1'b1;
    bus_data_ok = 1'b1;
    bus_rdata   = 32'h3C08BFAF;
    sb_q.push_back('{1'b0, 32'h3C08BFAF});
    tick();
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata   = 32'h0;
    e = sb_q.pop_front();
    n_checks++;
    if ({inst_ok, data_ok} !== {~e.is_data, e.is_data}) begin
      n_fail++;
      $display("FAIL fetch_latency: got inst_ok=%b data_ok=%b, expected 1 0", inst_ok, data_ok);
    end
    n_checks++;
    if (inst_rdata !== e.rdata) begin
      n_fail++;
      $display("FAIL fetch_rdata: got %h, expected %h", inst_rdata, e.rdata);
    end
    inst_req = 1'b0;
    tick();
    n_checks++;
    if ({inst_ok, busy, bus_req} !== 3'b000) begin
      n_fail++;
      $display("FAIL fetch_pulse_width: got ok=%b busy=%b req=%b, expected 000", inst_ok, busy, bus_req);
    end
    n_checks++;
    if (inst_rdata !== 32'h3C08BFAF) begin
      n_fail++;
      $display("FAIL fetch_rdata_hold: got %h, expected 3c08bfaf", inst_rdata);
    end
  endtask

  task automatic test_arbitration();
    exp_t e;
    bit   done;
    inst_req  = 1'b1;
    inst_addr = 32'hBFC00040;
    data_req  = 1'b1;
    data_wr   = 1'b0;
    data_be   = 4'b1111;
    data_addr = 32'h80001004;
    tick();
    n_checks++;
    if (bus_addr !== 32'h80001004 || bus_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL arb_data_first: got addr=%h wr=%b, expected 80001004 0", bus_addr, bus_wr);
    end
    sb_q.push_back('{1'b1, 32'h11223344});
    bus_serve(0, 0, 32'h11223344, done);
    e = sb_q.pop_front();
    n_checks++;
    if (!done || {inst_ok, data_ok} !== {~e.is_data, e.is_data} || data_rdata !== e.rdata) begin
      n_fail++;
      $display("FAIL arb_data_done: got inst_ok=%b data_ok=%b rdata=%h, expected 0 1 %h",
               inst_ok, data_ok, data_rdata, e.rdata);
    end
    data_addr = 32'h80002000;
    tick();
    n_checks++;
    if (bus_req !== 1'b1 || bus_addr !== 32'hBFC00040 || bus_be !== 4'b1111) begin
      n_fail++;
      $display("FAIL arb_inst_next: got req=%b addr=%h be=%b, expected 1 bfc00040 1111",
               bus_req, bus_addr, bus_be);
    end
    sb_q.push_back('{1'b0, 32'h0A0B0C0D});
    bus_serve(1, 1, 32'h0A0B0C0D, done);
    e = sb_q.pop_front();
    n_checks++;
    if (!done || {inst_ok, data_ok} !== {~e.is_data, e.is_data} || inst_rdata !== e.rdata) begin
      n_fail++;
      $display("FAIL arb_inst_done: got inst_ok=%b data_ok=%b rdata=%h, expected 1 0 %h",
               inst_ok, data_ok, inst_rdata, e.rdata);
    end
    inst_req = 1'b0;
    tick();
    n_checks++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h80002000) begin
      n_fail++;
      $display("FAIL back_to_back_grant: got req=%b addr=%h, expected 1 80002000", bus_req, bus_addr);
    end
    sb_q.push_back('{1'b1, 32'h55667788});
    bus_serve(0, 2, 32'h55667788, done);
    e = sb_q.pop_front();
    n_checks++;
    if (!done || {inst_ok, data_ok} !== {~e.is_data, e.is_data} || data_rdata !== e.rdata) begin
      n_fail++;
      $display("FAIL back_to_back_done: got inst_ok=%b data_ok=%b rdata=%h, expected 0 1 %h",
               inst_ok, data_ok, data_rdata, e.rdata);
    end
    data_req = 1'b0;
    tick();
    n_checks++;
    if (data_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_back_pulse: got data_ok=%b, expected 0", data_ok);
    end
  endtask

  task automatic test_zero_be_store();
    int req_seen;
    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_be    = 4'b0000;
    data_addr  = 32'h80000020;
    data_wdata = 32'h12345678;
    tick();
    req_seen = int'(bus_req === 1'b1);
    n_checks++;
    if (data_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_be_ok: got data_ok=%b, expected 1", data_ok);
    end
    data_req = 1'b0;
    tick();
    req_seen += int'(bus_req === 1'b1);
    n_checks++;
    if (req_seen !== 0) begin
      n_fail++;
      $display("FAIL zero_be_no_bus: bus_req seen %0d cycles, expected 0", req_seen);
    end
    n_checks++;
    if (data_ok !== 1'b0 || busy !== 1'b0 || data_rdata !== 32'h55667788) begin
      n_fail++;
      $display("FAIL zero_be_after: got ok=%b busy=%b rdata=%h, expected 0 0 55667788",
               data_ok, busy, data_rdata);
    end
  endtask

  task automatic test_store_delayed();
    int c;
    int req_cycles;
    int ok_cycle;
    int ok_base;
    bit stable;
    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_be    = 4'b0100;
    data_addr  = 32'h80000010;
    data_wdata = 32'h00AB0000;
    tick();
    data_be    = 4'b1001;
    data_addr  = 32'h900000F0;
    data_wdata = 32'hCAFEF00D;
    ok_base    = data_ok_cnt;
    req_cycles = 0;
    ok_cycle   = -1;
    stable     = 1'b1;
    c          = 0;
    while (ok_cycle < 0 && c < 15) begin
      if (bus_req === 1'b1) begin
        req_cycles++;
        if ({bus_wr, bus_be, bus_addr, bus_wdata} !== {1'b1, 4'b0100, 32'h80000010, 32'h00AB0000})
          stable = 1'b0;
      end
      if (data_ok === 1'b1) begin
        ok_cycle = c;
      end else begin
        bus_addr_ok = (c == 3);
        bus_data_ok = (c == 5);
        tick();
        c++;
      end
    end
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    data_req    = 1'b0;
    n_checks++;
    if (req_cycles !== 4 || stable !== 1'b1) begin
      n_fail++;
      $display("FAIL store_bus_req: got %0d cycles stable=%b, expected 4 cycles stable=1", req_cycles, stable);
    end
    n_checks++;
    if (ok_cycle !== 6) begin
      n_fail++;
      $display("FAIL store_ok_timing: got ok at cycle %0d, expected 6", ok_cycle);
    end
    tick();
    tick();
    n_checks++;
    if (data_ok_cnt - ok_base !== 1) begin
      n_fail++;
      $display("FAIL store_single_ok: got %0d pulses, expected 1", data_ok_cnt - ok_base);
    end
  endtask

  task automatic test_reset_in_wait();
    int ok_base;
    data_req  = 1'b1;
    data_wr   = 1'b0;
    data_be   = 4'b1111;
    data_addr = 32'h80003000;
    tick();
    bus_addr_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || bus_req !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_state: got busy=%b req=%b, expected 1 0", busy, bus_req);
    end
    ok_base  = data_ok_cnt + inst_ok_cnt;
    rst      = 1'b1;
    data_req = 1'b0;
    tick();
    rst         = 1'b0;
    bus_addr_ok = 1'b1;
    bus_data_ok = 1'b1;
    bus_rdata   = 32'hFFFF0000;
    tick();
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    tick();
    n_checks++;
    if (data_ok_cnt + inst_ok_cnt - ok_base !== 0) begin
      n_fail++;
      $display("FAIL reset_drop_ok: got %0d ok pulses, expected 0", data_ok_cnt + inst_ok_cnt - ok_base);
    end
    n_checks++;
    if (busy !== 1'b0 || bus_req !== 1'b0 || data_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_drop_state: got busy=%b req=%b rdata=%h, expected 0 0 0", busy, bus_req, data_rdata);
    end
  endtask

  task automatic test_timeout();
    int busy_cycles;
    int terr_cycles;
    int ok_at;
    inst_req  = 1'b1;
    inst_addr = 32'hBFC00100;
    tick();
    busy_cycles = 0;
    terr_cycles = 0;
    ok_at       = -1;
    for (int k = 0; k < 20; k++) begin
      if (busy === 1'b1) busy_cycles++;
      if (timeout_err === 1'b1) terr_cycles++;
      if (inst_ok === 1'b1 && ok_at < 0) begin
        ok_at = k;
`ifdef MEM_ARB_TIMEOUT_EN
        n_checks++;
        if (inst_rdata !== 32'hDEADBEEF || timeout_err !== 1'b1) begin
          n_fail++;
          $display("FAIL timeout_abort_data: got rdata=%h terr=%b, expected deadbeef 1", inst_rdata, timeout_err);
        end
        inst_req = 1'b0;
`endif
      end
      tick();
    end
`ifdef MEM_ARB_TIMEOUT_EN
    n_checks++;
    if (ok_at !== 8 || terr_cycles !== 1) begin
      n_fail++;
      $display("FAIL timeout_abort: got ok at %0d terr cycles %0d, expected 8 and 1", ok_at, terr_cycles);
    end
`else
    n_checks++;
    if (busy_cycles !== 20 || ok_at !== -1) begin
      n_fail++;
      $display("FAIL no_timeout_busy: got busy %0d cycles ok at %0d, expected 20 and -1", busy_cycles, ok_at);
    end
    n_checks++;
    if (terr_cycles !== 0) begin
      n_fail++;
      $display("FAIL no_timeout_err: got %0d cycles, expected 0", terr_cycles);
    end
`endif
    rst      = 1'b1;
    inst_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst         = 1'b1;
    inst_req    = 1'b0;
    inst_addr   = 32'h0;
    data_req    = 1'b0;
    data_wr     = 1'b0;
    data_be     = 4'b0000;
    data_addr   = 32'h0;
    data_wdata  = 32'h0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata   = 32'h0;
    test_reset();
    test_inst_fetch();
    test_arbitration();
    test_zero_be_store();
    test_store_delayed();
    test_reset_in_wait();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: cycles without bus progress before abort (used only with MEM_ARB_TIMEOUT_EN).
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- inst_req  in  1  fetch request, held until inst_ok
- inst_addr  in  32  fetch word address
- inst_ok  out  1  one-cycle fetch completion pulse
- inst_rdata  out  32  fetch data, valid with inst_ok
- data_req  in  1  load/store request, held until data_ok
- data_wr  in  1  1 = store, 0 = load
- data_be  in  4  store byte enables (MEM-stage calWE)
- data_addr  in  32  load/store address
- data_wdata  in  32  byte-lane-aligned store data (MEM-stage TrueRamData)
- data_ok  out  1  one-cycle load/store completion pulse
- data_rdata  out  32  load data, valid with data_ok
- bus_req  out  1  shared memory port request
- bus_wr  out  1  write strobe
- bus_be  out  4  byte enables
- bus_addr  out  32  address
- bus_wdata  out  32  write data
- bus_addr_ok  in  1  bus accepted request this cycle
- bus_data_ok  in  1  bus completed transaction this cycle
- bus_rdata  in  32  read data, valid with bus_data_ok
- busy  out  1  high whenever state != IDLE
- timeout_err  out  1  one-cycle abort pulse

Function
REQ-003 SHALL implement FSM IDLE, ADDR, WAIT; at most one outstanding bus transaction.
REQ-004 IDLE: no request pending -> stay; else grant one requester, latch its addr/wr/be/wdata and owner, go to ADDR next cycle.
REQ-005 Arbitration when both pending: data wins unless last completed grant was data, then inst wins; last-owner register resets to inst.
REQ-006 Inst transactions SHALL drive bus_wr=0, bus_be=4'b1111.
REQ-007 ADDR: bus_req=1 with latched fields; bus_addr_ok=0 -> stay; bus_addr_ok=1 -> WAIT; bus_addr_ok=1 and bus_data_ok=1 same cycle -> complete, go IDLE.
REQ-008 WAIT: bus_req=0; bus_data_ok=1 -> complete, go IDLE.
REQ-009 Complete: pulse owner's ok for exactly one cycle (cycle after bus_data_ok), rdata registered from bus_rdata; non-owner ok stays 0.
REQ-010 Store with data_be=4'b0000 SHALL complete without bus_req (data_ok one cycle after grant), modelling a suppressed/excepted store.
REQ-011 Best-case latency: req seen cycle N, bus_req cycle N+1, ok cycle N+2 if addr_ok and data_ok both in N+1.
REQ-012 Requester inputs changing after grant SHALL be ignored until the ok pulse; a requester whose req drops before grant is not serviced.
REQ-013 bus_addr_ok/bus_data_ok asserted in IDLE SHALL be ignored.
REQ-014 After completion, IDLE SHALL accept a new grant on the cycle the ok pulse is driven (back-to-back rate: one transaction per 3 cycles minimum).
REQ-015 inst_rdata/data_rdata SHALL hold last value between pulses.

Reset
REQ-016 rst=1 SHALL force IDLE, last-owner=inst, clear all latched fields and timeout counter.
REQ-017 Reset values: all outputs 0 (ok, rdata, bus_*, busy, timeout_err).
REQ-018 Reset mid-transaction SHALL drop the transaction with no ok pulse; late bus responses then ignored per REQ-013.

Configuration
REQ-019 Macro MEM_ARB_TIMEOUT_EN defined: counter clears on entering ADDR and on addr_ok, increments each cycle in ADDR/WAIT; reaching TIMEOUT_CYCLES forces IDLE, pulses owner's ok with rdata=32'hDEADBEEF and timeout_err=1 same cycle.
REQ-020 Macro undefined: no counter; ADDR/WAIT wait indefinitely; timeout_err tied 0; port list unchanged.

Verification
REQ-021 inst_req only, addr 0xBFC00000, bus acks addr_ok+data_ok in first bus_req cycle with rdata 0x3C08BFAF -> inst_ok one cycle later, inst_rdata=0x3C08BFAF, bus_wr=0, bus_be=1111.
REQ-022 inst_req and data_req (load, addr 0x80001004) both high from IDLE -> data serviced first; inst serviced next even if data_req reasserted.
REQ-023 Store be=0100, wdata 0x00AB0000, addr_ok delayed 3 cycles, data_ok 2 cycles later -> bus_req high 4 cycles with stable fields, single data_ok pulse.
REQ-024 Store be=0000 -> data_ok next cycle after grant, bus_req never asserted.
REQ-025 rst pulsed in WAIT, then stray bus_data_ok -> no ok pulse, busy=0, FSM IDLE.
REQ-026 With MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, bus silent -> abort after 8 cycles: ok pulse, rdata 0xDEADBEEF, timeout_err=1; without macro, busy stays 1.
